// File: rtl/fetcher.sv
// Instruction fetch unit: owns the PC, issues single outstanding icache
// requests, applies the predictor decision and pushes fetched instructions
// (with their predicted next PC) into the instruction queue. A ROB flush
// redirects the PC; an in-flight icache response is drained and discarded.
module fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clockIn,
  input  logic        resetIn,
  output logic        fetchValid,
  output logic [31:0] fetchAddr,
  input  logic        icacheValid,
  input  logic [31:0] icacheInstr,
  output logic [31:0] predAddr,
  input  logic        jumpIn,
  input  logic        queueFull,
  output logic        instrOutValid,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic        predTakenOut,
  output logic [31:0] nextPCOut,
  input  logic        flushValid,
  input  logic [31:0] flushPC
);

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    PREDICT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        out_valid_reg;
  logic [31:0] out_instr_reg;
  logic [31:0] out_pc_reg;
  logic        out_taken_reg;
  logic [31:0] out_next_pc_reg;

  logic        push;
  logic        fetch_req;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] pred_pc;
  logic        pred_taken;

  // Predicted next PC and direction for the latched instruction.
  always_comb begin
    imm_b      = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                  instr_reg[30:25], instr_reg[11:8], 1'b0};
    imm_j      = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12],
                  instr_reg[20], instr_reg[30:21], 1'b0};
    pred_pc    = pc_reg + 32'd4;
    pred_taken = 1'b0;
    if (instr_reg[6:0] == OP_JAL) begin
      pred_pc    = pc_reg + imm_j;
      pred_taken = 1'b1;
    end else if (instr_reg[6:0] == OP_BRANCH && jumpIn) begin
      pred_pc    = pc_reg + imm_b;
      pred_taken = 1'b1;
    end
  end

  // Next-state logic; a flush overrides any push and redirects the PC.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    push       = 1'b0;
    fetch_req  = 1'b0;
    case (state_reg)
      ISSUE: begin
        fetch_req  = 1'b1;
        state_next = flushValid ? DRAIN : WAIT;
      end
      WAIT: begin
        if (flushValid) begin
          state_next = icacheValid ? ISSUE : DRAIN;
        end else if (icacheValid) begin
          instr_next = icacheInstr;
          state_next = PREDICT;
        end
      end
      PREDICT: begin
        if (flushValid) begin
          state_next = ISSUE;
        end else if (!queueFull) begin
          push       = 1'b1;
          pc_next    = pred_pc;
          state_next = ISSUE;
        end
      end
      DRAIN: begin
        // The outstanding response is discarded; a flush only retargets pc.
        if (icacheValid) begin
          state_next = ISSUE;
        end
      end
      default: state_next = ISSUE;
    endcase
    if (flushValid) begin
      pc_next = flushPC;
    end
  end

  // State, PC and registered queue-push outputs.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      state_reg       <= ISSUE;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'h0;
      out_valid_reg   <= 1'b0;
      out_instr_reg   <= 32'h0;
      out_pc_reg      <= 32'h0;
      out_taken_reg   <= 1'b0;
      out_next_pc_reg <= 32'h0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      out_valid_reg <= push;
      if (push) begin
        out_instr_reg   <= instr_reg;
        out_pc_reg      <= pc_reg;
        out_taken_reg   <= pred_taken;
        out_next_pc_reg <= pred_pc;
      end
    end
  end

  // Request strobe is suppressed while reset is held so outputs read 0.
  assign fetchValid    = fetch_req & resetIn;
  assign fetchAddr     = pc_reg;
  assign predAddr      = pc_reg;
  assign instrOutValid = out_valid_reg;
  assign instrOut      = out_instr_reg;
  assign pcOut         = out_pc_reg;
  assign predTakenOut  = out_taken_reg;
  assign nextPCOut     = out_next_pc_reg;

endmodule

// File: tb/tb_fetcher.sv
// Randomized bench for fetcher: an icache/queue/ROB environment drives the
// DUT while a transaction-level model predicts every output each cycle.
module tb_fetcher;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        fetchValid;
  logic [31:0] fetchAddr;
  logic        icacheValid;
  logic [31:0] icacheInstr;
  logic [31:0] predAddr;
  logic        jumpIn;
  logic        queueFull;
  logic        instrOutValid;
  logic [31:0] instrOut;
  logic [31:0] pcOut;
  logic        predTakenOut;
  logic [31:0] nextPCOut;
  logic        flushValid;
  logic [31:0] flushPC;

  always #5 clockIn = ~clockIn;

  fetcher dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .fetchValid(fetchValid), .fetchAddr(fetchAddr),
    .icacheValid(icacheValid), .icacheInstr(icacheInstr),
    .predAddr(predAddr), .jumpIn(jumpIn), .queueFull(queueFull),
    .instrOutValid(instrOutValid), .instrOut(instrOut), .pcOut(pcOut),
    .predTakenOut(predTakenOut), .nextPCOut(nextPCOut),
    .flushValid(flushValid), .flushPC(flushPC)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Next PC from RISC-V rules, immediates built by weighted field sums.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic j, output logic taken);
    int imm;
    logic [6:0] op;
    op    = ins[6:0];
    imm   = 4;
    taken = 1'b0;
    if (op == 7'h6F) begin
      imm = (ins[31] ? -(1 << 20) : 0) + (int'(ins[19:12]) << 12)
          + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1);
      taken = 1'b1;
    end else if (op == 7'h63 && j) begin
      imm = (ins[31] ? -(1 << 12) : 0) + (int'(ins[7]) << 11)
          + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
      taken = 1'b1;
    end
    return pc + 32'(imm);
  endfunction

  // Model state: what the fetch unit is doing this cycle, at transaction level.
  logic [31:0] m_pc, m_instr;
  logic        m_issue, m_out, m_drain, m_held, m_push;
  logic [31:0] p_instr, p_pc, p_next;
  logic        p_taken;

  // Environment state.
  logic        busy;
  int          resp_cnt;
  logic [31:0] resp_addr;
  int          rst_cnt;
  logic        directed;
  int          dpush_n;
  int          dpush_cyc [3];
  logic [31:0] dpush_pc [3];
  int          total_pushes;

  initial begin
    logic [31:0] w, r;
    logic        t;
    logic [6:0]  ops [4];
    logic        inflight, nxt_push;

    ops[0] = 7'h13; ops[1] = 7'h6F; ops[2] = 7'h63; ops[3] = 7'h67;
    for (int i = 0; i < 256; i++) begin
      w = $urandom();
      mem[i] = {w[31:7], ops[$urandom_range(0, 3)]};
    end
    mem[0]   = 32'h00100093;  // addi x1,x0,1
    mem[1]   = 32'h00100093;
    mem[2]   = 32'h00100093;
    mem[64]  = 32'h0200006F;  // jal x0,+0x20 at 0x100
    mem[128] = 32'hFE000CE3;  // beq x0,x0,-8 at 0x200

    // Hand-computed anchors for the reference function.
    r = ref_next(32'h100, 32'h0200006F, 1'b0, t);
    chk("pin_jal_next", r, 32'h120);  chk("pin_jal_taken", {31'b0, t}, 32'h1);
    r = ref_next(32'h200, 32'hFE000CE3, 1'b1, t);
    chk("pin_beq_taken_next", r, 32'h1F8);
    r = ref_next(32'h200, 32'hFE000CE3, 1'b0, t);
    chk("pin_beq_nt_next", r, 32'h204); chk("pin_beq_nt_taken", {31'b0, t}, 32'h0);
    r = ref_next(32'hFFFFFFFC, 32'h00100093, 1'b1, t);
    chk("pin_wrap_next", r, 32'h0);

    resetIn = 1'b0; icacheValid = 1'b0; icacheInstr = '0; jumpIn = 1'b0;
    queueFull = 1'b0; flushValid = 1'b0; flushPC = '0;
    m_pc = 32'h0; m_instr = '0; m_issue = 1'b1; m_out = 1'b0; m_drain = 1'b0;
    m_held = 1'b0; m_push = 1'b0; p_instr = '0; p_pc = '0; p_next = '0; p_taken = 1'b0;
    busy = 1'b0; resp_cnt = 0; resp_addr = '0; rst_cnt = 0;
    directed = 1'b1; dpush_n = 0; total_pushes = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clockIn);
      #1;
      // Drive this cycle's inputs.
      if (!directed && rst_cnt == 0 && $urandom_range(0, 199) == 0)
        rst_cnt = $urandom_range(1, 2);
      resetIn = !(cyc < 3 || rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;
      icacheValid = 1'b0;
      icacheInstr = $urandom();
      if (!resetIn) begin
        busy = 1'b0;
      end else if (busy) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          icacheValid = 1'b1;
          icacheInstr = mem[resp_addr[9:2]];
          busy = 1'b0;
        end
      end
      jumpIn    = 1'($urandom_range(0, 1));
      queueFull = directed ? 1'b0 : ($urandom_range(0, 3) == 0);
      flushValid = 1'b0;
      case ($urandom_range(0, 3))
        0: flushPC = 32'h100;
        1: flushPC = 32'h200;
        2: flushPC = 32'h400;
        default: begin w = $urandom(); flushPC = {w[31:2], 2'b00}; end
      endcase
      if (!directed && $urandom_range(0, 24) == 0 && !(m_drain && icacheValid))
        flushValid = 1'b1;

      @(negedge clockIn);
      // Compare DUT outputs against the model for this cycle.
      if (cyc < 3) begin
        chk("reset_fetchValid", {31'b0, fetchValid}, 32'h0);
        chk("reset_instrOutValid", {31'b0, instrOutValid}, 32'h0);
        chk("reset_instrOut", instrOut, 32'h0);
        chk("reset_pcOut", pcOut, 32'h0);
        chk("reset_nextPCOut", nextPCOut, 32'h0);
        chk("reset_predTakenOut", {31'b0, predTakenOut}, 32'h0);
        chk("reset_fetchAddr", fetchAddr, 32'h0);
      end
      chk("fetchValid", {31'b0, fetchValid}, {31'b0, m_issue && resetIn});
      chk("fetchAddr", fetchAddr, m_pc);
      chk("predAddr", predAddr, m_pc);
      chk("instrOutValid", {31'b0, instrOutValid}, {31'b0, m_push});
      if (m_push) begin
        total_pushes++;
        chk("instrOut", instrOut, p_instr);
        chk("pcOut", pcOut, p_pc);
        chk("predTakenOut", {31'b0, predTakenOut}, {31'b0, p_taken});
        chk("nextPCOut", nextPCOut, p_next);
      end
      if (directed && instrOutValid && dpush_n < 3) begin
        dpush_cyc[dpush_n] = cyc;
        dpush_pc[dpush_n]  = pcOut;
        dpush_n++;
        if (dpush_n == 3) begin
          chk("first_push_cycle", 32'(dpush_cyc[0]), 32'd6);
          chk("push_spacing_1", 32'(dpush_cyc[1] - dpush_cyc[0]), 32'd3);
          chk("push_spacing_2", 32'(dpush_cyc[2] - dpush_cyc[1]), 32'd3);
          chk("straight_pc0", dpush_pc[0], 32'h0);
          chk("straight_pc1", dpush_pc[1], 32'h4);
          chk("straight_pc2", dpush_pc[2], 32'h8);
          directed = 1'b0;
        end
      end
      if (directed && cyc > 40) begin
        chk("directed_timeout", 32'(dpush_n), 32'd3);
        directed = 1'b0;
      end
      if (fetchValid) begin
        chk("single_outstanding", {31'b0, busy}, 32'h0);
        busy      = 1'b1;
        resp_cnt  = directed ? 1 : $urandom_range(1, 3);
        resp_addr = fetchAddr;
      end

      // Advance the model with this cycle's inputs.
      if (!resetIn) begin
        m_pc = 32'h0; m_issue = 1'b1; m_out = 1'b0; m_drain = 1'b0;
        m_held = 1'b0; m_push = 1'b0;
        p_instr = '0; p_pc = '0; p_next = '0; p_taken = 1'b0;
      end else begin
        nxt_push = 1'b0;
        if (flushValid) begin
          inflight = (m_issue || m_out) && !(m_out && icacheValid);
          m_pc   = flushPC;
          m_held = 1'b0;
          m_issue = !inflight;
          m_out   = inflight;
          m_drain = inflight;
        end else if (m_held) begin
          if (!queueFull) begin
            nxt_push = 1'b1;
            p_instr  = m_instr;
            p_pc     = m_pc;
            p_next   = ref_next(m_pc, m_instr, jumpIn, p_taken);
            m_pc     = p_next;
            m_held   = 1'b0;
            m_issue  = 1'b1;
          end
        end else if (m_issue) begin
          m_issue = 1'b0;
          m_out   = 1'b1;
        end else if (m_out && icacheValid) begin
          m_out = 1'b0;
          if (m_drain) begin
            m_drain = 1'b0;
            m_issue = 1'b1;
          end else begin
            m_held  = 1'b1;
            m_instr = icacheInstr;
          end
        end
        m_push = nxt_push;
      end
    end

    chk("enough_pushes", {31'b0, total_pushes > 100}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
